// File: rtl/flush_ctrl_mc_pkg.sv
// ---------------------------------------------------------------------------
// flush_ctrl_mc_pkg
// Shared types and constants for the multi-channel flush controller.
//   flush_fsm_e   : controller sequencing state
//   fence_kind_e  : which operation the sequencer is running
//   bp_resolve_t  : branch resolution bundle from EX (only is_mispredict used)
// ---------------------------------------------------------------------------
package flush_ctrl_mc_pkg;

  localparam int unsigned VLEN = 64;

  // fence.t resumes at the instruction after the committing fence.t
  localparam logic [VLEN-1:0] FENCE_T_PC_INC = VLEN'(4);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    CLEAR,
    PAD
  } flush_fsm_e;

  typedef enum logic {
    FENCE,
    FENCE_T
  } fence_kind_e;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic [VLEN-1:0] target_address;
    logic            is_mispredict;
    logic            is_taken;
  } bp_resolve_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/flush_ctrl_mc_ch_tracker.sv
// ---------------------------------------------------------------------------
// flush_ch_tracker
// Holds the per-channel pending bitmap for an in-flight flush, clears bits as
// channels acknowledge, and force-aborts after AckTimeout cycles in FLUSH.
// Ports:
//   clk_i, rst_ni, clr_i : clock, async active-low reset, sync clear
//   start_i              : load start_mask_i into the pending bitmap
//   start_mask_i         : channels to flush for this operation
//   active_i             : controller is in FLUSH
//   flush_ack_i          : per-channel acknowledge
//   pending_o            : registered pending bitmap (drives flush_req_o)
//   all_done_o           : nothing left pending once this cycle's acks land
//   timeout_o            : one-cycle pulse, coincident with the aborted bitmap
// ---------------------------------------------------------------------------
module flush_ch_tracker
  import flush_ctrl_mc_pkg::*;
#(
  parameter int unsigned NrFlushCh  = 2,
  parameter int unsigned AckTimeout = 0,
  parameter int unsigned CntW       = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 start_i,
  input  logic [NrFlushCh-1:0] start_mask_i,
  input  logic                 active_i,
  input  logic [NrFlushCh-1:0] flush_ack_i,
  output logic [NrFlushCh-1:0] pending_o,
  output logic                 all_done_o,
  output logic                 timeout_o
);

  localparam logic [CntW-1:0] DwellLoad = (AckTimeout > 0) ? CntW'(AckTimeout - 1) : '0;

  logic [NrFlushCh-1:0] pending_q;
  logic [NrFlushCh-1:0] remaining;
  logic [CntW-1:0]      dwell_q;
  logic                 timeout_q;
  logic                 expire;

  // Acks on channels that are not pending fall out of the AND.
  assign remaining  = pending_q & ~flush_ack_i;
  assign all_done_o = (remaining == '0);

  // Dwell is a down-counter loaded on accept; terminal count means the
  // channels have had AckTimeout cycles. An ack landing in the same cycle wins.
  assign expire = (AckTimeout != 0) && active_i && (dwell_q == '0) && !all_done_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      dwell_q   <= '0;
      timeout_q <= 1'b0;
    end else if (clr_i) begin
      pending_q <= '0;
      dwell_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire;
      if (start_i) begin
        pending_q <= start_mask_i;
        dwell_q   <= DwellLoad;
      end else if (active_i) begin
        pending_q <= expire ? '0 : remaining;
        if (dwell_q != '0) dwell_q <= dwell_q - CntW'(1);
      end
    end
  end

  assign pending_o = pending_q;
  assign timeout_o = timeout_q;

endmodule

// File: rtl/flush_ctrl_mc.sv
// ---------------------------------------------------------------------------
// flush_ctrl_mc
// Pipeline flush / set-PC generation plus a sequencer that flushes N cache or
// buffer channels over req/ack and runs the constant-time fence.t sequence.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no operation; accepts fence / fence.i / fence.t
//   FLUSH | waiting for every pending channel to ack (or timeout)
//   CLEAR | fence_t_clr_o high for ClrCycles cycles (fence.t only)
//   PAD   | idle wait until fence.t reaches its fixed latency
//
// Ports:
//   clk_i, rst_ni, clr_i         : clock, async active-low reset, sync clear
//   boot_addr_i, pc_commit_i     : reset value / commit PC for rst_addr_o
//   rst_addr_o                   : resume address after fence.t
//   halt_csr_i, halt_o           : WFI halt in, commit halt out
//   eret_i, ex_valid_i, set_debug_pc_i, resolved_branch_i,
//   flush_csr_i, flush_commit_i, fence_i, fence_i_i, sfence_vma_i,
//   fence_t_i                    : flush-causing events
//   set_pc_commit_o, flush_*_o   : combinational pipeline controls
//   flush_req_o, flush_ack_i     : per-channel flush handshake
//   fence_t_clr_o                : microarchitectural clear
//   flush_timeout_o              : pulse on forced channel abort
// ---------------------------------------------------------------------------
module flush_ctrl_mc
  import flush_ctrl_mc_pkg::*;
#(
  parameter int unsigned          NrFlushCh   = 2,
  parameter logic [NrFlushCh-1:0] FenceChMask = 'b01,
  parameter bit                   WtDcache    = 1'b0,
  parameter int unsigned          ClrCycles   = 16,
  parameter int unsigned          PadCycles   = 64,
  parameter int unsigned          AckTimeout  = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic [VLEN-1:0]      boot_addr_i,
  input  logic [VLEN-1:0]      pc_commit_i,
  output logic [VLEN-1:0]      rst_addr_o,
  input  logic                 halt_csr_i,
  output logic                 halt_o,
  input  logic                 eret_i,
  input  logic                 ex_valid_i,
  input  logic                 set_debug_pc_i,
  input  bp_resolve_t          resolved_branch_i,
  input  logic                 flush_csr_i,
  input  logic                 flush_commit_i,
  input  logic                 fence_i,
  input  logic                 fence_i_i,
  input  logic                 sfence_vma_i,
  input  logic [19:0]          fence_t_i,
  output logic                 set_pc_commit_o,
  output logic                 flush_if_o,
  output logic                 flush_unissued_instr_o,
  output logic                 flush_id_o,
  output logic                 flush_ex_o,
  output logic                 flush_bp_o,
  output logic                 flush_icache_o,
  output logic                 flush_tlb_o,
  output logic [NrFlushCh-1:0] flush_req_o,
  input  logic [NrFlushCh-1:0] flush_ack_i,
  output logic                 fence_t_clr_o,
  output logic                 flush_timeout_o
);

  localparam int unsigned   CntMax  = max3(PadCycles, ClrCycles, AckTimeout);
  localparam int unsigned   CntW    = (CntMax < 1) ? 1 : $clog2(CntMax + 1);
  localparam int unsigned   TotW    = CntW + 1;
  localparam logic [TotW-1:0] PadLim  = TotW'(PadCycles);
  localparam logic [CntW-1:0] ClrLoad = CntW'(ClrCycles - 1);

  flush_fsm_e      state_q;
  fence_kind_e     kind_q;
  logic [VLEN-1:0] rst_addr_q;
  logic [CntW-1:0] total_q;
  logic [CntW-1:0] clr_cnt_q;

  logic            fence_t_req;
  logic            fence_req;
  logic            start;
  logic            all_done;
  logic [TotW-1:0] total_ext;
  logic            unused_bp;

  assign fence_t_req = |fence_t_i;
  assign fence_req   = (fence_i | fence_i_i) & ~WtDcache;
  assign start       = (state_q == IDLE) & (fence_t_req | fence_req);
  assign total_ext   = {1'b0, total_q};

  assign unused_bp = ^{resolved_branch_i.valid, resolved_branch_i.pc,
                       resolved_branch_i.target_address, resolved_branch_i.is_taken};

  flush_ch_tracker #(
    .NrFlushCh (NrFlushCh),
    .AckTimeout(AckTimeout),
    .CntW      (CntW)
  ) u_ch_tracker (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (clr_i),
    .start_i     (start),
    .start_mask_i(fence_t_req ? {NrFlushCh{1'b1}} : FenceChMask),
    .active_i    (state_q == FLUSH),
    .flush_ack_i (flush_ack_i),
    .pending_o   (flush_req_o),
    .all_done_o  (all_done),
    .timeout_o   (flush_timeout_o)
  );

  // Later events override earlier ones; exception-class events must not
  // redirect to the commit PC, so they clear set_pc_commit_o last.
  always_comb begin
    set_pc_commit_o        = 1'b0;
    flush_if_o             = 1'b0;
    flush_unissued_instr_o = 1'b0;
    flush_id_o             = 1'b0;
    flush_ex_o             = 1'b0;
    flush_bp_o             = 1'b0;
    flush_icache_o         = 1'b0;
    flush_tlb_o            = 1'b0;
    if (resolved_branch_i.is_mispredict) begin
      flush_if_o             = 1'b1;
      flush_unissued_instr_o = 1'b1;
    end
    if (fence_i | fence_i_i | sfence_vma_i | flush_csr_i | flush_commit_i) begin
      set_pc_commit_o        = 1'b1;
      flush_if_o             = 1'b1;
      flush_unissued_instr_o = 1'b1;
      flush_id_o             = 1'b1;
      flush_ex_o             = 1'b1;
    end
    if (fence_i_i)    flush_icache_o = 1'b1;
    if (sfence_vma_i) flush_tlb_o    = 1'b1;
    if (fence_t_req)  flush_icache_o = 1'b1;
    if (ex_valid_i | eret_i | set_debug_pc_i) begin
      set_pc_commit_o        = 1'b0;
      flush_if_o             = 1'b1;
      flush_unissued_instr_o = 1'b1;
      flush_id_o             = 1'b1;
      flush_ex_o             = 1'b1;
      flush_bp_o             = 1'b1;
    end
  end

  // total_q counts from 0 starting the cycle after accept and saturates, so in
  // cycle k after accept it holds k-1. PAD leaves when the next value would
  // reach PadCycles-1, which returns IDLE exactly PadCycles cycles after accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      kind_q     <= FENCE;
      rst_addr_q <= boot_addr_i;
      total_q    <= '0;
      clr_cnt_q  <= '0;
    end else if (clr_i) begin
      state_q    <= IDLE;
      kind_q     <= FENCE;
      rst_addr_q <= boot_addr_i;
      total_q    <= '0;
      clr_cnt_q  <= '0;
    end else begin
      if ((state_q != IDLE) && (total_q != '1)) total_q <= total_q + CntW'(1);
      unique case (state_q)
        IDLE: begin
          if (fence_t_req) begin
            kind_q     <= FENCE_T;
            rst_addr_q <= pc_commit_i + FENCE_T_PC_INC;
            total_q    <= '0;
            state_q    <= FLUSH;
          end else if (fence_req) begin
            kind_q  <= FENCE;
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (all_done) begin
            if (kind_q == FENCE_T) begin
              clr_cnt_q <= ClrLoad;
              state_q   <= CLEAR;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        CLEAR: begin
          if (clr_cnt_q == '0) begin
            state_q <= ((total_ext + TotW'(1)) < PadLim) ? PAD : IDLE;
          end else begin
            clr_cnt_q <= clr_cnt_q - CntW'(1);
          end
        end
        PAD: begin
          if ((total_ext + TotW'(2)) >= PadLim) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rst_addr_o    = rst_addr_q;
  assign fence_t_clr_o = (state_q == CLEAR);
  assign halt_o        = halt_csr_i | (state_q != IDLE);

`ifndef SYNTHESIS
  // Commit is halted outside IDLE, so a new fence there means upstream broke.
  a_no_fence_when_busy : assert property (
    @(posedge clk_i) disable iff (!rst_ni || clr_i)
    (state_q != IDLE) |-> !(fence_i || fence_i_i || fence_t_req)
  );
`endif

endmodule

// File: tb/tb_flush_ctrl_mc.sv
module tb_flush_ctrl_mc;
  import flush_ctrl_mc_pkg::*;

  localparam int K_REQ = 0, K_CLR_R = 1, K_CLR_F = 2, K_TO = 3;
  localparam int K_HALT = 4, K_ADDR = 5, K_CTL = 6, K_PADDR = 7;
  localparam logic [63:0] BOOT = 64'h0000_0000_0000_1000;

  typedef struct {
    int          kind;
    int          cyc;
    logic [63:0] val;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, clr, halt_csr, eret, ex_valid, set_debug_pc;
  logic flush_csr, flush_commit, fence, fence_ii, sfence;
  logic [63:0] boot_addr, pc_commit;
  logic [19:0] fence_t;
  logic [1:0]  ack;
  bp_resolve_t rb;

  logic [63:0] a_addr, b_addr;
  logic a_halt, a_spc, a_if, a_un, a_id, a_ex, a_bp, a_ic, a_tlb, a_clr, a_to;
  logic b_halt, b_spc, b_if, b_un, b_id, b_ex, b_bp, b_ic, b_tlb, b_clr, b_to;
  logic [1:0] a_req, b_req;

  flush_ctrl_mc u_dut (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .boot_addr_i(boot_addr),
    .pc_commit_i(pc_commit), .rst_addr_o(a_addr), .halt_csr_i(halt_csr), .halt_o(a_halt),
    .eret_i(eret), .ex_valid_i(ex_valid), .set_debug_pc_i(set_debug_pc),
    .resolved_branch_i(rb), .flush_csr_i(flush_csr), .flush_commit_i(flush_commit),
    .fence_i(fence), .fence_i_i(fence_ii), .sfence_vma_i(sfence), .fence_t_i(fence_t),
    .set_pc_commit_o(a_spc), .flush_if_o(a_if), .flush_unissued_instr_o(a_un),
    .flush_id_o(a_id), .flush_ex_o(a_ex), .flush_bp_o(a_bp), .flush_icache_o(a_ic),
    .flush_tlb_o(a_tlb), .flush_req_o(a_req), .flush_ack_i(ack),
    .fence_t_clr_o(a_clr), .flush_timeout_o(a_to)
  );

  flush_ctrl_mc #(.AckTimeout(10)) u_dut_to (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .boot_addr_i(boot_addr),
    .pc_commit_i(pc_commit), .rst_addr_o(b_addr), .halt_csr_i(halt_csr), .halt_o(b_halt),
    .eret_i(eret), .ex_valid_i(ex_valid), .set_debug_pc_i(set_debug_pc),
    .resolved_branch_i(rb), .flush_csr_i(flush_csr), .flush_commit_i(flush_commit),
    .fence_i(fence), .fence_i_i(fence_ii), .sfence_vma_i(sfence), .fence_t_i(fence_t),
    .set_pc_commit_o(b_spc), .flush_if_o(b_if), .flush_unissued_instr_o(b_un),
    .flush_id_o(b_id), .flush_ex_o(b_ex), .flush_bp_o(b_bp), .flush_icache_o(b_ic),
    .flush_tlb_o(b_tlb), .flush_req_o(b_req), .flush_ack_i(ack),
    .fence_t_clr_o(b_clr), .flush_timeout_o(b_to)
  );

  // ctl bits: [12]halt [11]set_pc [10]if [9]unissued [8]id [7]ex [6]bp
  //           [5]icache [4]tlb [3:2]req [1]clr [0]timeout
  logic [12:0] a_ctl, b_ctl, m_ctl, prev_ctl;
  logic [63:0] m_addr, prev_addr;
  bit          sel = 1'b0;
  bit          mon_en = 1'b0;
  bit          probe = 1'b0;

  assign a_ctl  = {a_halt, a_spc, a_if, a_un, a_id, a_ex, a_bp, a_ic, a_tlb, a_req, a_clr, a_to};
  assign b_ctl  = {b_halt, b_spc, b_if, b_un, b_id, b_ex, b_bp, b_ic, b_tlb, b_req, b_clr, b_to};
  assign m_ctl  = sel ? b_ctl : a_ctl;
  assign m_addr = sel ? b_addr : a_addr;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  base = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_REQ:   return "flush_req";
      K_CLR_R: return "clr_rise";
      K_CLR_F: return "clr_fall";
      K_TO:    return "timeout";
      K_HALT:  return "halt";
      K_ADDR:  return "rst_addr";
      K_CTL:   return "ctl_vec";
      default: return "addr_probe";
    endcase
  endfunction

  task automatic check(input int k, input logic [63:0] v);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected %s at c%0d: got %0h, required no event", kname(k), cyc - base, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.val != v) begin
        bad++;
        $display("FAIL %s: got %s@c%0d=%0h, required %s@c%0d=%0h", kname(e.kind),
                 kname(k), cyc - base, v, kname(e.kind), e.cyc - base, e.val);
      end
    end
  endtask

  // Monitor: every observable output event pops the next expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (m_ctl[3:2] != prev_ctl[3:2]) check(K_REQ, 64'(m_ctl[3:2]));
      if (m_ctl[1] && !prev_ctl[1]) check(K_CLR_R, 64'd1);
      if (!m_ctl[1] && prev_ctl[1]) check(K_CLR_F, 64'd0);
      if (m_ctl[0]) check(K_TO, 64'd1);
      if (m_ctl[12] != prev_ctl[12]) check(K_HALT, 64'(m_ctl[12]));
      if (m_addr != prev_addr) check(K_ADDR, m_addr);
      if (probe) begin
        check(K_CTL, 64'(m_ctl));
        check(K_PADDR, m_addr);
      end
    end
    prev_ctl  <= m_ctl;
    prev_addr <= m_addr;
  end

  task automatic push(input int k, input int c, input logic [63:0] v);
    ev_t e;
    e.kind = k;
    e.cyc  = base + c;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int k);
    while (cyc - base < k) step();
  endtask

  task automatic clear_inputs();
    clr = 0; halt_csr = 0; eret = 0; ex_valid = 0; set_debug_pc = 0;
    flush_csr = 0; flush_commit = 0; fence = 0; fence_ii = 0; sfence = 0;
    fence_t = '0; ack = '0; rb = '0; pc_commit = '0; probe = 0;
  endtask

  task automatic start_test(input bit s);
    mon_en = 0;
    rst_n  = 0;
    clear_inputs();
    repeat (3) step();
    rst_n = 1;
    sel   = s;
    repeat (2) step();
    mon_en = 1;
    step();
    base = cyc;
  endtask

  initial begin
    boot_addr = BOOT;
    rst_n = 0;
    clear_inputs();

    // reset state
    start_test(0);
    push(K_CTL, 0, 64'd0);
    push(K_PADDR, 0, BOOT);
    probe = 1;
    goto(1); probe = 0;
    goto(3);

    // fence: ch0 only, ack at c5
    start_test(0);
    push(K_CTL, 0, 64'(13'b0_11111_0_0_0_00_0_0));
    push(K_PADDR, 0, BOOT);
    push(K_REQ, 1, 64'd1);
    push(K_HALT, 1, 64'd1);
    push(K_REQ, 6, 64'd0);
    push(K_HALT, 6, 64'd0);
    fence = 1; probe = 1;
    goto(1); fence = 0; probe = 0;
    goto(5); ack = 2'b01;
    goto(6); ack = 2'b00;
    goto(9);

    // fence.t with padding to 64
    start_test(0);
    push(K_CTL, 0, 64'(13'b0_00000_0_1_0_00_0_0));
    push(K_PADDR, 0, BOOT);
    push(K_REQ, 1, 64'd3);
    push(K_HALT, 1, 64'd1);
    push(K_ADDR, 1, 64'h0000_0000_8000_0104);
    push(K_REQ, 4, 64'd2);
    push(K_REQ, 8, 64'd0);
    push(K_CLR_R, 8, 64'd1);
    push(K_CLR_F, 24, 64'd0);
    push(K_HALT, 64, 64'd0);
    fence_t = 20'h00400; pc_commit = 64'h0000_0000_8000_0100; probe = 1;
    goto(1); fence_t = '0; probe = 0;
    goto(3); ack = 2'b01;
    goto(4); ack = 2'b00;
    goto(7); ack = 2'b10;
    goto(8); ack = 2'b00;
    goto(68);

    // fence.t with late acks: no padding, latency not clamped
    start_test(0);
    push(K_REQ, 1, 64'd3);
    push(K_HALT, 1, 64'd1);
    push(K_ADDR, 1, 64'h14);
    push(K_REQ, 81, 64'd0);
    push(K_CLR_R, 81, 64'd1);
    push(K_CLR_F, 97, 64'd0);
    push(K_HALT, 97, 64'd0);
    fence_t = 20'h00001; pc_commit = 64'h10;
    goto(1); fence_t = '0;
    goto(80); ack = 2'b11;
    goto(81); ack = 2'b00;
    goto(100);

    // ack timeout on the AckTimeout=10 instance
    start_test(1);
    push(K_REQ, 1, 64'd1);
    push(K_HALT, 1, 64'd1);
    push(K_REQ, 11, 64'd0);
    push(K_TO, 11, 64'd1);
    push(K_HALT, 12, 64'd0);
    fence = 1;
    goto(1); fence = 0;
    goto(20);

    // priorities, fence.t beats fence, clear mid-CLEAR
    start_test(0);
    push(K_CTL, 0, 64'(13'b0_01111_1_0_0_00_0_0));
    push(K_PADDR, 0, BOOT);
    rb.is_mispredict = 1; ex_valid = 1; probe = 1;
    goto(1);
    push(K_CTL, 1, 64'(13'b0_11111_0_0_1_00_0_0));
    push(K_PADDR, 1, BOOT);
    rb = '0; ex_valid = 0; sfence = 1;
    goto(2);
    push(K_CTL, 2, 64'(13'b0_11111_0_1_0_00_0_0));
    push(K_PADDR, 2, BOOT);
    push(K_REQ, 3, 64'd3);
    push(K_HALT, 3, 64'd1);
    push(K_ADDR, 3, 64'h204);
    push(K_REQ, 5, 64'd0);
    push(K_CLR_R, 5, 64'd1);
    push(K_CLR_F, 11, 64'd0);
    push(K_HALT, 11, 64'd0);
    push(K_ADDR, 11, BOOT);
    sfence = 0; fence = 1; fence_t = 20'h80000; pc_commit = 64'h200;
    goto(3); fence = 0; fence_t = '0; probe = 0;
    goto(4); ack = 2'b11;
    goto(5); ack = 2'b00;
    goto(10); clr = 1;
    goto(11); clr = 0;
    goto(14);

    // async reset mid-FLUSH drops the request without a clock edge
    start_test(0);
    push(K_REQ, 1, 64'd1);
    push(K_HALT, 1, 64'd1);
    push(K_REQ, 3, 64'd0);
    push(K_HALT, 3, 64'd0);
    fence = 1;
    goto(1); fence = 0;
    goto(3); rst_n = 0;
    goto(5); mon_en = 0; rst_n = 1;
    goto(7);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_events: got %0d still queued, required 0 (next kind %s at c%0d)",
               exp_q.size(), kname(exp_q[0].kind), exp_q[0].cyc - base);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
